// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and data memory, with store-to-load forwarding.
// Optional: define STORE_BUF_COALESCE_EN to merge a store into the youngest matching entry.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 12,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          MemRead,
   input  logic          MemWrite,
   input  logic [AW-1:0] address,
   input  logic [DW-1:0] writeData,
   output logic [DW-1:0] readData,
   output logic          stall,
   output logic          empty,
   output logic [AW-1:0] memAddress,
   output logic [DW-1:0] memWriteData,
   output logic          memWrite,
   output logic          memRead,
   input  logic [DW-1:0] memReadData
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addrMem [DEPTH];
   logic [DW-1:0] dataMem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic          full;
   logic          pop;
   logic          push;
   logic          coalesce;
   logic          fwdHit;
   logic [DW-1:0] fwdData;
`ifdef STORE_BUF_COALESCE_EN
   logic [PW-1:0] matchIdx;
`endif

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign pop   = (count != '0) && !MemRead;

   // Walk entries oldest to youngest so the last hit is the youngest match.
   always_comb begin
      logic [PW-1:0] idx;
      idx     = '0;
      fwdHit  = 1'b0;
      fwdData = '0;
`ifdef STORE_BUF_COALESCE_EN
      matchIdx = head;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < count) && (addrMem[idx] == address)) begin
            fwdHit  = 1'b1;
            fwdData = dataMem[idx];
`ifdef STORE_BUF_COALESCE_EN
            matchIdx = idx;
`endif
         end
      end
   end

`ifdef STORE_BUF_COALESCE_EN
   // A head-only match that pops this cycle would vanish, so it gets a fresh entry instead.
   assign coalesce = MemWrite && fwdHit && !((matchIdx == head) && pop);
`else
   assign coalesce = 1'b0;
`endif

   assign stall = MemWrite && full && !coalesce;
   assign push  = MemWrite && !full && !coalesce;

   assign readData = (MemRead && fwdHit) ? fwdData : memReadData;

   always_comb begin
      memRead      = MemRead;
      memWrite     = pop;
      memAddress   = address;
      memWriteData = '0;
      if (pop) begin
         memAddress   = addrMem[head];
         memWriteData = dataMem[head];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Entry storage is deliberately left out of reset; count alone defines validity.
   always_ff @(posedge clk) begin
      if (push) begin
         addrMem[tail] <= address;
         dataMem[tail] <= writeData;
      end
`ifdef STORE_BUF_COALESCE_EN
      if (coalesce) dataMem[matchIdx] <= writeData;
`endif
   end

endmodule
